// File: rtl/i2s_dac_tx_pkg.sv
// Shared audio constants and types for the I2S DAC transmitter.
package i2s_dac_tx_pkg;
  localparam int   SAMPLE_W  = 24;
  localparam logic CH_LEFT   = 1'b1;
  localparam logic CH_RIGHT  = 1'b0;
  localparam int   I2S_DELAY = 1;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } tx_state_e;
endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample stream from the EQ stage into the DAC transmitter.
interface i2s_dac_tx_if;
  logic [31:0] data_in;
  logic        data_valid;

  modport master (output data_in, data_valid);
  modport slave  (input  data_in, data_valid);
endinterface

// File: rtl/i2s_tx_chan_buf.sv
// One channel's sample buffer: pending word, last-sent word, bypass and
// underrun/overrun detection at slot load.
module i2s_tx_chan_buf
  import i2s_dac_tx_pkg::*;
#(
  parameter int DW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          load_i,
  output logic [DW-1:0] load_data_o,
  output logic          underrun_o,
  output logic          overrun_o
);
  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] last_q, last_d;
  logic          valid_q, valid_d;

  always_comb begin
    // Priority: buffered sample, then same-cycle write, then repeat last word
    load_data_o = last_q;
    if (valid_q) begin
      load_data_o = pend_q;
    end else if (wr_i) begin
      load_data_o = wr_data_i;
    end

    underrun_o = load_i && !valid_q && !wr_i;
    overrun_o  = wr_i && valid_q && !load_i;

    pend_d  = wr_i ? wr_data_i : pend_q;
    valid_d = valid_q;
    if (load_i) begin
      valid_d = valid_q && wr_i;
    end else if (wr_i) begin
      valid_d = 1'b1;
    end
    last_d = load_i ? load_data_o : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: syncs to the codec LRCLK, loads one word per slot and
// shifts it out MSB-first with the standard one-bclk delay.
module i2s_dac_tx
  import i2s_dac_tx_pkg::*;
#(
  parameter int DW    = SAMPLE_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lrc,
  i2s_dac_tx_if.slave      smp,
  input  logic             mute,
  input  logic             clr_stat,
  output logic             dacdat,
  output logic             underrun,
  output logic             overrun,
  output logic [CNT_W-1:0] underrun_cnt
);
  localparam int BCW = $clog2(DW + 1);

  tx_state_e        state_q, state_d;
  logic             lrc_q, lrc_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             dacdat_q, dacdat_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             slot_edge;
  logic [DW-1:0]    word;
  logic [DW-1:0]    load_val [2];
  logic [1:0]       buf_ur;
  logic [1:0]       buf_ov;
  logic             unused_hi;

  assign unused_hi = ^smp.data_in[31:DW];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic CH = (gi == 0) ? CH_RIGHT : CH_LEFT;
      i2s_tx_chan_buf #(.DW(DW)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_i        (smp.data_valid && (lrc == CH)),
        .wr_data_i   (smp.data_in[DW-1:0]),
        .load_i      (slot_edge && (lrc == CH)),
        .load_data_o (load_val[gi]),
        .underrun_o  (buf_ur[gi]),
        .overrun_o   (buf_ov[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    lrc_d     = lrc;
    slot_edge = (state_q == RUN) && (lrc != lrc_q);
    if (state_q == SYNC) begin
      state_d = RUN;
    end

    word      = mute ? '0 : load_val[lrc];
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    dacdat_d  = 1'b0;
    // The edge cycle itself drives the MSB, so DW-1 bits remain afterwards
    if (slot_edge) begin
      dacdat_d  = word[DW-1];
      shift_d   = word << 1;
      bit_cnt_d = BCW'(DW - I2S_DELAY);
    end else if (bit_cnt_q != '0) begin
      dacdat_d  = shift_q[DW-1];
      shift_d   = shift_q << 1;
      bit_cnt_d = bit_cnt_q - BCW'(1);
    end

    underrun_d = |buf_ur;
    overrun_d  = |buf_ov;
    cnt_d      = cnt_q;
    if (clr_stat) begin
      cnt_d = underrun_d ? CNT_W'(1) : '0;
    end else if (underrun_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      lrc_q      <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lrc_q      <= lrc_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dacdat       = dacdat_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
  assign underrun_cnt = cnt_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Slot-level bench for i2s_dac_tx: expected serial bits and pulses are queued
// per cycle and compared against the DUT on the falling edge.
module tb_i2s_dac_tx;
  localparam int DW    = 24;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lrc = 1'b0;
  logic             mute = 1'b0;
  logic             clr_stat = 1'b0;
  logic             dacdat;
  logic             underrun;
  logic             overrun;
  logic [CNT_W-1:0] underrun_cnt;

  i2s_dac_tx_if smp_if ();

  i2s_dac_tx #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lrc          (lrc),
    .smp          (smp_if),
    .mute         (mute),
    .clr_stat     (clr_stat),
    .dacdat       (dacdat),
    .underrun     (underrun),
    .overrun      (overrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dac;
    logic ur;
    logic ov;
  } exp_t;

  typedef struct {
    logic        ch;
    int          len;
    logic        byp;
    logic [31:0] bdata;
    logic        m;
    int          nwr;
    logic [31:0] wa;
    logic [31:0] wb;
    logic        clr_mid;
    logic [23:0] exp_word;
    logic        exp_ur;
  } slot_t;

  exp_t  sb[$];
  logic  bits_q[$];
  slot_t tbl[20];
  int    errors = 0;
  int    checks = 0;
  int    exp_cnt = 0;
  logic  cur_ur = 1'b0;
  logic  cur_ov = 1'b0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // One bclk: queue what this cycle must produce, clock it, compare.
  task automatic step();
    exp_t e;
    e.dac = (bits_q.size() > 0) ? bits_q.pop_front() : 1'b0;
    e.ur  = cur_ur;
    e.ov  = cur_ov;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check1("dacdat", {31'd0, dacdat}, {31'd0, e.dac});
    check1("underrun", {31'd0, underrun}, {31'd0, e.ur});
    check1("overrun", {31'd0, overrun}, {31'd0, e.ov});
    cur_ur              = 1'b0;
    cur_ov              = 1'b0;
    smp_if.data_valid   = 1'b0;
    clr_stat            = 1'b0;
    mute                = 1'b0;
  endtask

  task automatic edge_cyc(input logic ch, input logic byp, input logic [31:0] bdata,
                          input logic m, input logic clr, input logic [23:0] exp_word,
                          input logic exp_ur);
    lrc               = ch;
    smp_if.data_valid = byp;
    smp_if.data_in    = bdata;
    mute              = m;
    clr_stat          = clr;
    bits_q.delete();
    for (int i = DW - 1; i >= 0; i--) bits_q.push_back(exp_word[i]);
    cur_ur = exp_ur;
    if (clr) exp_cnt = exp_ur ? 1 : 0;
    else if (exp_ur && exp_cnt < 255) exp_cnt++;
    step();
  endtask

  task automatic body(input int n, input int nwr, input logic [31:0] wa,
                      input logic [31:0] wb, input logic clr_mid);
    for (int i = 1; i < n; i++) begin
      if (nwr >= 1 && i == 5) begin
        smp_if.data_valid = 1'b1;
        smp_if.data_in    = wa;
      end
      if (nwr >= 2 && i == 9) begin
        smp_if.data_valid = 1'b1;
        smp_if.data_in    = wb;
        cur_ov            = 1'b1;
      end
      if (clr_mid && i == 12) begin
        clr_stat = 1'b1;
        exp_cnt  = 0;
      end
      step();
    end
    check1("underrun_cnt", {24'd0, underrun_cnt}, exp_cnt);
  endtask

  initial begin
    //          ch len byp bdata          m  nwr wa            wb            clr exp_word     ur
    tbl[0]  = '{1, 32, 1, 32'h00A5A5A5, 0, 1, 32'h00123456, 32'h0,        0, 24'hA5A5A5, 0};
    tbl[1]  = '{0, 32, 0, 32'h0,        0, 1, 32'h00654321, 32'h0,        0, 24'h3C3C3C, 0};
    tbl[2]  = '{1, 32, 0, 32'h0,        0, 1, 32'h00A5A5A5, 32'h0,        0, 24'h123456, 0};
    tbl[3]  = '{0, 32, 0, 32'h0,        0, 1, 32'h003C3C3C, 32'h0,        0, 24'h654321, 0};
    tbl[4]  = '{1, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'hA5A5A5, 0};
    tbl[5]  = '{0, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h3C3C3C, 0};
    tbl[6]  = '{1, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'hA5A5A5, 1};
    tbl[7]  = '{0, 32, 0, 32'h0,        0, 2, 32'h00111111, 32'h00222222, 1, 24'h3C3C3C, 1};
    tbl[8]  = '{1, 32, 0, 32'h0,        0, 1, 32'h007FFFFF, 32'h0,        0, 24'hA5A5A5, 1};
    tbl[9]  = '{0, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h222222, 0};
    tbl[10] = '{1, 32, 0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 24'h000000, 0};
    tbl[11] = '{0, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h222222, 1};
    tbl[12] = '{1, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h7FFFFF, 1};
    tbl[13] = '{0, 32, 1, 32'h000F0F0F, 0, 1, 32'h0013579B, 32'h0,        0, 24'h0F0F0F, 0};
    tbl[14] = '{1, 32, 1, 32'hFF800001, 0, 0, 32'h0,        32'h0,        0, 24'h800001, 0};
    tbl[15] = '{0, 32, 1, 32'h002468AC, 0, 0, 32'h0,        32'h0,        0, 24'h13579B, 0};
    tbl[16] = '{1, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h800001, 1};
    tbl[17] = '{0, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h2468AC, 0};
    tbl[18] = '{1, 10, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h800001, 1};
    tbl[19] = '{0, 32, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 24'h2468AC, 1};

    smp_if.data_in    = '0;
    smp_if.data_valid = 1'b0;

    repeat (3) @(negedge clk);
    check1("rst_dacdat", {31'd0, dacdat}, 32'd0);
    check1("rst_underrun", {31'd0, underrun}, 32'd0);
    check1("rst_overrun", {31'd0, overrun}, 32'd0);
    check1("rst_cnt", {24'd0, underrun_cnt}, 32'd0);
    rst_n = 1'b1;

    step();
    step();
    smp_if.data_valid = 1'b1;
    smp_if.data_in    = 32'h003C3C3C;
    step();
    step();

    for (int s = 0; s < 20; s++) begin
      edge_cyc(tbl[s].ch, tbl[s].byp, tbl[s].bdata, tbl[s].m, 1'b0,
               tbl[s].exp_word, tbl[s].exp_ur);
      body(tbl[s].len, tbl[s].nwr, tbl[s].wa, tbl[s].wb, tbl[s].clr_mid);
      $display("slot %0d ch=%0d word=%06h ur=%0b cnt=%0d", s, tbl[s].ch,
               tbl[s].exp_word, tbl[s].exp_ur, exp_cnt);
    end

    // Long starvation: both channels repeat their last word until saturation
    for (int s = 0; s < 260; s++) begin
      edge_cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 24'h800001, 1'b1);
      body(26, 0, 32'h0, 32'h0, 1'b0);
      edge_cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 24'h2468AC, 1'b1);
      body(26, 0, 32'h0, 32'h0, 1'b0);
    end
    check1("cnt_saturated", {24'd0, underrun_cnt}, 32'd255);
    $display("starvation done cnt=%0d", underrun_cnt);

    // Clear coincident with an underrun leaves 1, a later clear leaves 0
    edge_cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 24'h800001, 1'b1);
    check1("cnt_clr_with_ur", {24'd0, underrun_cnt}, 32'd1);
    body(26, 0, 32'h0, 32'h0, 1'b1);
    $display("clear done cnt=%0d", underrun_cnt);

    // Asynchronous reset in the middle of an all-ones word
    edge_cyc(1'b0, 1'b1, 32'h00FFFFFF, 1'b0, 1'b0, 24'hFFFFFF, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check1("async_rst_dacdat", {31'd0, dacdat}, 32'd0);
    check1("async_rst_cnt", {24'd0, underrun_cnt}, 32'd0);
    bits_q.delete();
    exp_cnt = 0;
    lrc     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released with lrc=1");

    // lrc already high at release: no slot until it falls
    for (int i = 0; i < 4; i++) step();
    edge_cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 24'h000000, 1'b1);
    body(32, 0, 32'h0, 32'h0, 1'b0);
    check1("first_load_cnt", {24'd0, underrun_cnt}, 32'd1);
    $display("first slot after reset cnt=%0d", underrun_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
